// File: rtl/nz_compressor.sv
// nz_compressor: multi-lane zero-skipping activation compressor.
// Define NZC_THRESHOLD_EN to add a magnitude threshold for the zero test.
module nz_compressor #(
  parameter int N         = 16,
  parameter int LANES     = 4,
  parameter int BRICK     = 16,
  parameter int ADDR_SIZE = 16,
  localparam int OW = $clog2(BRICK),
  localparam int CW = $clog2(BRICK + 1),
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic [ADDR_SIZE-1:0] i_base_addr,
`ifdef NZC_THRESHOLD_EN
  input  logic [N-1:0]         i_threshold,
`endif
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [LANES*N-1:0]   i_data,
  output logic                 o_wr_valid,
  input  logic                 i_wr_ready,
  output logic [N-1:0]         o_wr_data,
  output logic [OW-1:0]        o_wr_ofs,
  output logic [ADDR_SIZE-1:0] o_wr_addr,
  output logic                 o_brick_done,
  output logic [CW-1:0]        o_brick_nnz,
  output logic                 o_overflow
);

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_t;

  localparam logic [OW-1:0] LAST_POS = OW'(BRICK - LANES);

  state_t r_state;
  state_t w_state_nxt;

  logic [LANES*N-1:0]   r_data;
  logic [LANES-1:0]     r_mask;
  logic [OW-1:0]        r_gpos;
  logic [OW-1:0]        r_bpos;
  logic                 r_last;
  logic [ADDR_SIZE-1:0] r_idx;
  logic [CW-1:0]        r_cnt;
  logic                 r_done;
  logic [CW-1:0]        r_nnz;
  logic                 r_ovf;

  logic [LANES-1:0] w_mask;
  logic [LANES-1:0] w_clr;
  logic [LW-1:0]    w_sel;
  logic [N-1:0]     w_sel_data;
  logic             w_drain;
  logic             w_acc;
  logic             w_hs;
  logic             w_last_entry;

  // Per-lane non-zero test on the incoming group
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      logic [N-1:0] lane;
`ifdef NZC_THRESHOLD_EN
      logic [N-1:0] mag;
      logic         is_min;
`endif
      lane = i_data[k*N +: N];
`ifdef NZC_THRESHOLD_EN
      mag       = lane[N-1] ? (~lane + 1'b1) : lane;
      is_min    = (lane == {1'b1, {(N-1){1'b0}}});
      w_mask[k] = (|lane) && (is_min || (mag >= i_threshold));
`else
      w_mask[k] = |lane;
`endif
    end
  end

  // Lowest pending lane wins
  always_comb begin
    w_sel      = '0;
    w_sel_data = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (r_mask[k]) begin
        w_sel      = LW'(k);
        w_sel_data = r_data[k*N +: N];
      end
    end
    w_clr        = r_mask;
    w_clr[w_sel] = 1'b0;
    w_last_entry = (w_clr == '0);
  end

  assign w_drain = (r_state == S_DRAIN);
  assign w_acc   = i_valid & ~w_drain;
  assign w_hs    = w_drain & i_wr_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_wr_valid  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid && (|w_mask)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        o_wr_valid = 1'b1;
        if (i_wr_ready && w_last_entry) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_clear) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
      r_mask <= '0;
      r_gpos <= '0;
      r_bpos <= '0;
      r_last <= 1'b0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_nnz  <= '0;
      r_ovf  <= 1'b0;
    end else if (i_clear) begin
      r_mask <= '0;
      r_gpos <= '0;
      r_bpos <= '0;
      r_last <= 1'b0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_acc) begin
        r_data <= i_data;
        r_mask <= w_mask;
        r_gpos <= r_bpos;
        r_last <= (r_bpos == LAST_POS);
        r_bpos <= r_bpos + OW'(LANES);
        // An empty closing group completes the brick right away
        if ((w_mask == '0) && (r_bpos == LAST_POS)) begin
          r_done <= 1'b1;
          r_nnz  <= r_cnt;
          r_cnt  <= '0;
        end
      end
      if (w_hs) begin
        r_mask <= w_clr;
        r_idx  <= r_idx + 1'b1;
        if (&r_idx) r_ovf <= 1'b1;
        if (w_last_entry && r_last) begin
          r_done <= 1'b1;
          r_nnz  <= r_cnt + 1'b1;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_wr_data    = w_drain ? w_sel_data : '0;
  assign o_wr_ofs     = w_drain ? (r_gpos + OW'(w_sel)) : '0;
  assign o_wr_addr    = i_base_addr + r_idx;
  assign o_brick_done = r_done;
  assign o_brick_nnz  = r_nnz;
  assign o_overflow   = r_ovf;

endmodule

// File: doc/nz_compressor.md
# nz_compressor

Multi-lane zero-skipping compressor for the activation path. It accepts groups of LANES activations per handshake and drops zero values. Each surviving value is emitted as one entry per cycle, carrying its position within the current brick and a write address of base plus a running index, into the activation SRAM. It sits between the neuron output stage and the SRAM write port, and reports per-brick non-zero counts for the dispatcher.

## Interface
- N, 16: activation width (signed two's complement)
- LANES, 4: activations per input group
- BRICK, 16: activations per brick; must be a multiple of LANES, power of two
- ADDR_SIZE, 16: SRAM address width
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous and active-high
- i_clear  in  1  synchronous clear: idx, brick position and state to reset values; pending group discarded
- i_base_addr  in  ADDR_SIZE  SRAM base address, used combinationally
- i_valid  in  1  input group valid
- o_ready  out  1  input group accepted when i_valid & o_ready
- i_data  in  LANES*N  group; lane k at bits [k*N +: N]
- o_wr_valid  out  1  entry valid
- i_wr_ready  in  1  entry consumed when o_wr_valid & i_wr_ready
- o_wr_data  out  N  non-zero value
- o_wr_ofs  out  $clog2(BRICK)  position of the value within its brick
- o_wr_addr  out  ADDR_SIZE  i_base_addr + idx, modulo 2^ADDR_SIZE
- o_brick_done  out  1  one-cycle pulse at brick completion
- o_brick_nnz  out  $clog2(BRICK+1)  non-zero count of the completed brick; held until next pulse
- o_overflow  out  1  sticky: idx wrapped past 2^ADDR_SIZE-1

## Operation
- States: IDLE (o_ready=1, o_wr_valid=0) and DRAIN (o_ready=0, o_wr_valid=1).
- Acceptance in IDLE:
  - registers the group and a LANES-bit non-zero mask;
  - registers gpos, the group's starting position in the brick.
  - Goes to DRAIN if the mask is non-zero; otherwise stays in IDLE.
- DRAIN:
  - the lowest set mask bit k selects o_wr_data = lane k and o_wr_ofs = gpos + k;
  - on each entry handshake, bit k is cleared, idx increments by 1 and the brick nnz counter increments by 1;
  - the cycle the last bit is consumed, state returns to IDLE.
- Brick position advances by LANES per accepted group and wraps to 0 after BRICK values.
- Brick completion happens when the group covering position BRICK-1 is finished: on acceptance if its mask is zero, otherwise on its final entry handshake. At completion:
  - o_brick_done pulses;
  - o_brick_nnz is loaded;
  - the nnz counter clears.
- idx does not reset at brick boundaries; only i_rst and i_clear reset it.
- Wrap: when idx increments from 2^ADDR_SIZE-1 to 0, o_overflow sets. It is cleared only by i_rst or i_clear.
- i_clear has priority over a simultaneous handshake, and no entry is counted that cycle.

## Timing
- Reset values:
  - state IDLE, o_ready=1;
  - o_wr_valid=0, o_wr_data=0, o_wr_ofs=0;
  - idx=0, so o_wr_addr=i_base_addr;
  - o_brick_done=0, o_brick_nnz=0, o_overflow=0.
- Latency: the first entry of an accepted group is valid the cycle after acceptance.
- A group with k non-zeros occupies k DRAIN cycles at full i_wr_ready. The next group is accepted the cycle after the last entry handshake, and an all-zero group costs 1 cycle.
- o_brick_done is registered: it is high in the cycle after the completing event.
- While o_wr_valid=1 and i_wr_ready=0, o_wr_data, o_wr_ofs and o_wr_addr hold stable; o_wr_addr also depends on i_base_addr.
- i_rst mid-DRAIN drops the remaining entries immediately, with no partial brick pulse.

## Configuration
- NZC_THRESHOLD_EN defined:
  - adds port i_threshold (in, N, unsigned magnitude);
  - a lane counts as zero when |value| < i_threshold; the most negative value counts as non-zero;
  - i_threshold=0 behaves as an exact compare.
- Undefined: the port is absent and the zero test is the exact compare value == 0.

## Test plan
Parameters: LANES=4, BRICK=8, base 0x0100, i_wr_ready=1 unless stated.
- Reset: assert i_rst asynchronously between edges -> all outputs take their reset values immediately, o_wr_addr=0x0100.
- First group (lanes 0..3) = {0,5,0,7} -> entries (5, ofs 1, 0x0100) then (7, ofs 3, 0x0101); o_ready low for 2 cycles.
- Second group {0,0,0,9} -> entry (9, ofs 7, 0x0102); next cycle o_brick_done=1 with nnz=3; the following brick's offsets restart at 0.
- Back-pressure: i_wr_ready low for 3 cycles during DRAIN -> data, offset and address stable; no idx advance.
- All-zero brick: two zero groups -> no o_wr_valid; o_brick_done with nnz=0 the cycle after the second acceptance; o_ready stays 1.
- Wrap and clear: ADDR_SIZE=4, 17 entries -> the 17th entry goes to base+0 and o_overflow=1; pulsing i_clear -> o_overflow=0, idx=0. With NZC_THRESHOLD_EN and threshold 4, the group {3,-3,4,-5} emits only 4 and -5.
